// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed digit scan controller sharing one seven-segment decoder
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SHOW_CYCLES  = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  output logic [3:0]              num,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    blank,
  output logic                    frame_done
);

  localparam int MAX_CYC = (SHOW_CYCLES > GUARD_CYCLES) ? SHOW_CYCLES : GUARD_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int DW      = $clog2(NUM_DIGITS);
  localparam int VW      = 4 * NUM_DIGITS;

  localparam logic [DW-1:0]         LAST_DIGIT = DW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0]         SHOW_LAST  = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0]         GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

  typedef enum logic {
    ST_SHOW,
    ST_GUARD
  } state_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         digit_q, digit_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  start_q, start_d;
  logic [VW-1:0]         pending_q, pending_d;
  logic [VW-1:0]         active_q, active_d;
  logic [3:0]            num_q, num_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  blank_q, blank_d;
  logic                  frame_done_q, frame_done_d;

  always_comb begin
    logic [NUM_DIGITS-1:0] zero_above;

    state_d   = state_q;
    digit_d   = digit_q;
    cnt_d     = cnt_q;
    start_d   = start_q;
    pending_d = load ? value : pending_q;
    active_d  = active_q;

    case (state_q)
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = ST_GUARD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GUARD: begin
        // The post-reset guard gets one extra leading cycle so frame_done never overlaps reset.
        if (start_q) begin
          start_d = 1'b0;
        end else if (cnt_q == GUARD_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
          if (digit_q == LAST_DIGIT) begin
            digit_d  = '0;
            active_d = load ? value : pending_q;
          end else begin
            digit_d = digit_q + DW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_GUARD;
      end
    endcase

    zero_above = '0;
    zero_above[NUM_DIGITS-1] = (active_d[VW-1 -: 4] == 4'h0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      zero_above[k] = zero_above[k+1] && (active_d[4*k +: 4] == 4'h0);
    end

    // Outputs are decoded from the next state so the registered copies match the state they describe.
    frame_done_d = (state_d == ST_GUARD) && !start_d && (digit_d == LAST_DIGIT) && (cnt_d == GUARD_LAST);
    an_d         = (state_d == ST_SHOW) ? (AN_ONE << digit_d) : '0;
    num_d        = active_d[{digit_d, 2'b00} +: 4];
    blank_d      = (state_d == ST_GUARD) || (blank_lz && (digit_d != '0) && zero_above[digit_d]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_GUARD;
      digit_q      <= LAST_DIGIT;
      cnt_q        <= '0;
      start_q      <= 1'b1;
      pending_q    <= '0;
      active_q     <= '0;
      num_q        <= 4'h0;
      an_q         <= '0;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      cnt_q        <= cnt_d;
      start_q      <= start_d;
      pending_q    <= pending_d;
      active_q     <= active_d;
      num_q        <= num_d;
      an_q         <= an_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign num        = num_q;
  assign an         = an_q;
  assign blank      = blank_q;
  assign frame_done = frame_done_q;

endmodule
